// File: rtl/rns_op_dispatch.sv
// Buffered operand dispatcher: routes a W-bit residue to one of NCH per-operation FIFOs.
// Optional per-channel accepted-write counters are enabled by defining RNS_DISPATCH_STAT_EN.
module rns_op_dispatch #(
  parameter int W     = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [SELW-1:0]   in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*W-1:0]  out_data,
`ifdef RNS_DISPATCH_STAT_EN
  output logic [NCH*16-1:0] stat_cnt,
`endif
  output logic              err_sel
);
  // Handshake: a beat moves on an edge where valid & ready; ready never depends on valid.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [NCH-1:0] sel_hit;
  logic [NCH-1:0] full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic           in_range;
  logic           accept;

  always_comb begin
    sel_hit = '0;
    for (int c = 0; c < NCH; c++) sel_hit[c] = (in_sel == SELW'(c));
  end

  assign in_range = |sel_hit;
  assign in_ready = ~flush & ~(|(sel_hit & full));
  assign accept   = in_valid & in_ready;
  assign push     = accept ? sel_hit : '0;
  assign pop      = out_valid & out_ready & {NCH{~flush}};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_n;
    logic [CW-1:0] count, cnt_n;
    logic [W-1:0]  head_q, head_n;

    // Head register tracks the entry that will be at the front after this edge.
    always_comb begin
      rd_n   = rd_ptr + PW'(pop[c]);
      cnt_n  = count + CW'(push[c]) - CW'(pop[c]);
      head_n = mem[rd_n];
      if (push[c] && ((count - CW'(pop[c])) == '0)) head_n = in_data;
      if (cnt_n == '0) head_n = '0;
    end

    always_ff @(posedge clk) begin
      if (push[c]) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        head_q <= '0;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        head_q <= '0;
      end else begin
        rd_ptr <= rd_n;
        wr_ptr <= wr_ptr + PW'(push[c]);
        count  <= cnt_n;
        head_q <= head_n;
      end
    end

    assign full[c]            = (count == CW'(DEPTH));
    assign out_valid[c]       = (count != '0);
    assign out_data[c*W +: W] = head_q;

`ifdef RNS_DISPATCH_STAT_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             stat_q <= '0;
      else if (flush)                         stat_q <= '0;
      else if (push[c] && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
    end
    assign stat_cnt[c*16 +: 16] = stat_q;
`endif
  end

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_sel <= 1'b0;
    else if (accept && !in_range)  err_sel <= 1'b1;
  end
endmodule

// File: tb/tb_rns_op_dispatch.sv
// Self-checking bench for rns_op_dispatch: vector table, directed corner sequences,
// and randomized traffic against a queue-based channel model.
module tb_rns_op_dispatch;
  localparam int W = 4, NCH = 4, SELW = 2, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, flush, in_valid, in_ready, err_sel;
  logic [W-1:0]      in_data;
  logic [SELW-1:0]   in_sel;
  logic [NCH-1:0]    out_valid, out_ready;
  logic [NCH*W-1:0]  out_data;

  logic              flush3, in_valid3, in_ready3, err_sel3;
  logic [W-1:0]      in_data3;
  logic [SELW-1:0]   in_sel3;
  logic [2:0]        out_valid3, out_ready3;
  logic [3*W-1:0]    out_data3;
`ifdef RNS_DISPATCH_STAT_EN
  logic [NCH*16-1:0] stat_cnt;
  logic [3*16-1:0]   stat_cnt3;
`endif

  rns_op_dispatch #(.W(W), .NCH(NCH), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef RNS_DISPATCH_STAT_EN
    .stat_cnt(stat_cnt),
`endif
    .err_sel(err_sel)
  );

  rns_op_dispatch #(.W(W), .NCH(3), .SELW(SELW), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3),
`ifdef RNS_DISPATCH_STAT_EN
    .stat_cnt(stat_cnt3),
`endif
    .err_sel(err_sel3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q [NCH][$];
  logic [W-1:0] got_q2 [$];
  int  stat_m [NCH];
  bit  last_acc;

  typedef struct {
    logic           v;
    logic [SELW-1:0] sel;
    logic [W-1:0]   d;
    logic [NCH-1:0] ordy;
    logic           e_rdy;
    logic [NCH-1:0] e_vld;
    logic [NCH*W-1:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (flush) return 1'b0;
    if (int'(in_sel) >= NCH) return 1'b1;
    return exp_q[in_sel].size() < DEPTH;
  endfunction

  task automatic check_model();
    logic [NCH-1:0]   ev;
    logic [NCH*W-1:0] ed;
    ev = '0;
    ed = '0;
    for (int c = 0; c < NCH; c++)
      if (exp_q[c].size() > 0) begin
        ev[c] = 1'b1;
        ed[c*W +: W] = exp_q[c][0];
      end
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", 64'(out_data), 64'(ed));
    chk("err_sel", 64'(err_sel), 64'd0);
`ifdef RNS_DISPATCH_STAT_EN
    for (int c = 0; c < NCH; c++)
      chk("stat_cnt", 64'(stat_cnt[c*16 +: 16]), 64'(stat_m[c]));
`endif
    if (out_valid[2] && out_ready[2] && !flush) got_q2.push_back(out_data[2*W +: W]);
  endtask

  task automatic edge_step();
    bit acc;
    @(posedge clk);
    acc = in_valid && model_ready();
    if (flush) begin
      for (int c = 0; c < NCH; c++) begin
        exp_q[c].delete();
        stat_m[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++)
        if (exp_q[c].size() > 0 && out_ready[c]) void'(exp_q[c].pop_front());
      if (acc && int'(in_sel) < NCH) begin
        exp_q[in_sel].push_back(in_data);
        if (stat_m[in_sel] < 65535) stat_m[in_sel]++;
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    edge_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 0; in_valid = 0; in_data = '0; in_sel = '0; out_ready = '0;
    flush3 = 0; in_valid3 = 0; in_data3 = '0; in_sel3 = '0; out_ready3 = '0;
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      stat_m[c] = 0;
    end
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_err_sel", 64'(err_sel), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push(input int sel, input logic [W-1:0] d);
    int k;
    in_valid = 1'b1;
    in_sel   = SELW'(sel);
    in_data  = d;
    k = 0;
    forever begin
      cycle();
      if (last_acc) break;
      k++;
      if (k > 20) begin
        chk("push_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 2'd0, 4'h5, 4'hF, 1'b1, 4'b0000, 16'h0000};
    tbl[1] = '{1'b1, 2'd1, 4'hA, 4'hF, 1'b1, 4'b0001, 16'h0005};
    tbl[2] = '{1'b1, 2'd2, 4'h3, 4'hF, 1'b1, 4'b0010, 16'h00A0};
    tbl[3] = '{1'b1, 2'd3, 4'hF, 4'hF, 1'b1, 4'b0100, 16'h0300};
    tbl[4] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b1000, 16'hF000};
    tbl[5] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 16'h0000};

    // One operand per channel, each visible for exactly one cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].e_rdy));
      chk("tbl_out_valid", 64'(out_valid), 64'(tbl[i].e_vld));
      chk("tbl_out_data", 64'(out_data), 64'(tbl[i].e_data));
      check_model();
      edge_step();
    end

    // Fill channel 2 while stalled, then drain in order.
    do_reset();
    out_ready = 4'b1011;
    got_q2.delete();
    for (int i = 1; i <= 4; i++) push(2, W'(i));
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'd5;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    check_model();
    edge_step();
    cycle();
    out_ready = 4'b1111;
    push(2, 4'd5);
    repeat (8) cycle();
    chk("order_len", 64'(got_q2.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < got_q2.size()) chk("order_val", 64'(got_q2[i]), 64'(i + 1));

    // Stalled full channel 2 must not block channel 0.
    do_reset();
    out_ready = 4'b1011;
    for (int i = 0; i < 4; i++) push(2, W'($urandom_range(0, 15)));
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_sel   = (i % 2 == 1) ? 2'd0 : 2'd2;
      in_data  = W'($urandom_range(0, 15));
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();

    // Flush with a pending write: everything empties, nothing is written.
    do_reset();
    out_ready = '0;
    push(0, 4'h1); push(0, 4'h2); push(1, 4'h3); push(1, 4'h4);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h7; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    check_model();
    edge_step();

    // Random traffic, including flushes and pointer wrap.
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = SELW'($urandom_range(0, NCH - 1));
      in_data   = W'($urandom_range(0, 15));
      out_ready = NCH'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0;

`ifdef RNS_DISPATCH_STAT_EN
    do_reset();
    out_ready = '1;
    for (int i = 0; i < 3; i++) push(1, W'(i));
    @(negedge clk);
    chk("stat_three", 64'(stat_cnt[1*16 +: 16]), 64'd3);
    edge_step();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h9;
    repeat (65540) cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stat_saturate", 64'(stat_cnt[0 +: 16]), 64'hFFFF);
    edge_step();
`endif

    // Out-of-range select on the three-channel instance.
    do_reset();
    @(negedge clk);
    chk("err3_reset", 64'(err_sel3), 64'd0);
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 4'h9; out_ready3 = '0;
    @(negedge clk);
    chk("err3_in_ready", 64'(in_ready3), 64'd1);
    @(posedge clk); #1 in_valid3 = 1'b0;
    @(negedge clk);
    chk("err3_set", 64'(err_sel3), 64'd1);
    chk("err3_discard_vld", 64'(out_valid3), 64'd0);
    chk("err3_discard_data", 64'(out_data3), 64'd0);
    in_valid3 = 1'b1; in_sel3 = 2'd1; in_data3 = 4'h6;
    @(posedge clk); #1 in_valid3 = 1'b0;
    @(negedge clk);
    chk("err3_ch1_vld", 64'(out_valid3), 64'b010);
    chk("err3_ch1_data", 64'(out_data3), 64'h060);
    flush3 = 1'b1;
    @(posedge clk); #1 flush3 = 1'b0;
    @(negedge clk);
    chk("err3_sticky", 64'(err_sel3), 64'd1);
    chk("err3_flush_vld", 64'(out_valid3), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("err3_async_clr", 64'(err_sel3), 64'd0);
    #20 rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
